// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcode, state and iteration constants for the EX mul/div unit
package muldiv_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_NONE7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - ID/EX operand bundle and HI/LO result bus of the mul/div unit
interface ex_muldiv_if #(
  parameter int msb = 31
);
  logic         in_valid;
  logic [2:0]   in_op;
  logic [msb:0] in_rs_data;
  logic [msb:0] in_rt_data;
  logic         flush;
  logic         out_busy;
  logic         out_done;
  logic [msb:0] out_hi;
  logic [msb:0] out_lo;

  modport master (
    output in_valid, in_op, in_rs_data, in_rt_data, flush,
    input  out_busy, out_done, out_hi, out_lo
  );

  modport slave (
    input  in_valid, in_op, in_rs_data, in_rt_data, flush,
    output out_busy, out_done, out_hi, out_lo
  );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add (multiply) or restoring shift-subtract (divide) step
module muldiv_step #(
  parameter int msb = 31
) (
  input  logic [msb:0] acc,
  input  logic [msb:0] opd,
  input  logic         div_mode,
  input  logic         sel,
  output logic [msb:0] acc_next,
  output logic         bit_next
);

  logic [msb+1:0] sum;
  logic [msb+1:0] shifted;
  logic [msb+1:0] diff;

  // Multiply: sel is the multiplier LSB, bit_next feeds the product low half from the top.
  // Divide: sel is the next dividend bit, bit_next is the quotient bit; diff MSB is the borrow.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, opd};
    shifted  = {acc, sel};
    diff     = shifted - {1'b0, opd};
    acc_next = acc;
    bit_next = 1'b0;
    if (div_mode) begin
      if (!diff[msb+1]) begin
        acc_next = diff[msb:0];
        bit_next = 1'b1;
      end else begin
        acc_next = shifted[msb:0];
        bit_next = 1'b0;
      end
    end else if (sel) begin
      acc_next = sum[msb+1:1];
      bit_next = sum[0];
    end else begin
      acc_next = {1'b0, acc[msb:1]};
      bit_next = acc[0];
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int msb = ITER_COUNT - 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        db_ena,
  ex_muldiv_if.slave  bus
);

  localparam int W  = msb + 1;
  localparam int CW = $clog2(W);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [msb:0]    acc;
  logic [msb:0]    mq;
  logic [msb:0]    opd;
  logic [msb:0]    hi;
  logic [msb:0]    lo;
  logic            is_div;
  logic            neg_res;
  logic            neg_rem;
  logic            busy;
  logic            done;

  op_e             op;
  logic            op_signed;
  logic            op_div;
  logic            rt_zero;
  logic [msb:0]    rs_mag;
  logic [msb:0]    rt_mag;
  logic [msb:0]    acc_next;
  logic            bit_next;
  logic            step_sel;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  prod_neg;

  always_comb begin
    op        = op_e'(bus.in_op);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    rt_zero   = (bus.in_rt_data == '0);
    rs_mag    = (op_signed && bus.in_rs_data[msb]) ? -bus.in_rs_data : bus.in_rs_data;
    rt_mag    = (op_signed && bus.in_rt_data[msb]) ? -bus.in_rt_data : bus.in_rt_data;
    step_sel  = is_div ? mq[msb] : mq[0];
    prod      = {acc, mq};
    prod_neg  = -prod;
  end

  muldiv_step #(.msb(msb)) u_step (
    .acc      (acc),
    .opd      (opd),
    .div_mode (is_div),
    .sel      (step_sel),
    .acc_next (acc_next),
    .bit_next (bit_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mq      <= '0;
      opd     <= '0;
      hi      <= '0;
      lo      <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (db_ena) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            case (op)
              OP_MTHI: hi <= bus.in_rs_data;
              OP_MTLO: lo <= bus.in_rs_data;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                busy   <= 1'b1;
                is_div <= op_div;
                opd    <= rt_mag;
                // Divide by zero bypasses RUN: FIX then passes acc/mq straight to HI/LO.
                if (op_div && rt_zero) begin
                  acc     <= bus.in_rs_data;
                  mq      <= '1;
                  neg_res <= 1'b0;
                  neg_rem <= 1'b0;
                  cnt     <= '0;
                  state   <= FIX;
                end else begin
                  acc     <= '0;
                  mq      <= rs_mag;
                  neg_res <= op_signed && (bus.in_rs_data[msb] ^ bus.in_rt_data[msb]);
                  neg_rem <= op_signed && bus.in_rs_data[msb];
                  cnt     <= CW'(msb);
                  state   <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_next;
            mq  <= is_div ? {mq[msb-1:0], bit_next} : {bit_next, mq[msb:1]};
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (bus.flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (is_div) begin
              lo <= neg_res ? -mq : mq;
              hi <= neg_rem ? -acc : acc;
            end else begin
              {hi, lo} <= neg_res ? prod_neg : prod;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_busy = busy;
  assign bus.out_done = done;
  assign bus.out_hi   = hi;
  assign bus.out_lo   = lo;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit for the EX stage, fed directly by the ID/EX pipeline register outputs (rs/rt read data plus a decoded mul/div opcode). It executes MULT, MULTU, DIV and DIVU over 33 cycles and holds the architectural HI/LO registers, which MTHI/MTLO also write. It drives a busy flag back to the hazard unit, which stalls ID/EX issue while an operation is in flight.

## Interface
Parameters:
- msb, 31, most significant bit of the data path (width = msb+1)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- db_ena  in  1  debug-unit clock enable; when 0, all state and outputs hold
- in_valid  in  1  an operation is presented this cycle
- in_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
- in_rs_data  in  msb+1  rs operand (dividend / multiplicand / MTxx source)
- in_rt_data  in  msb+1  rt operand (divisor / multiplier)
- flush  in  1  abort any in-flight operation (branch/exception squash)
- out_busy  out  1  operation in flight; hazard unit stalls ID/EX issue
- out_done  out  1  one-cycle pulse, HI/LO just updated by a mul/div
- out_hi  out  msb+1  HI register
- out_lo  out  msb+1  LO register

## Operation
- All register updates are qualified by db_ena. An edge with db_ena=0 is a no-op.
- FSM states:
  - IDLE: accepts new operations.
  - RUN: iterates, counter counts 31 down to 0.
  - FIX: applies sign correction and writes HI/LO.
- In IDLE with in_valid and no flush:
  - MULT/MULTU/DIV/DIVU with a nonzero divisor: latch operands, go to RUN, counter=31.
  - MTHI/MTLO: write in_rs_data to HI/LO at that edge and stay in IDLE. No done pulse.
  - Op none: ignored.
- Signed ops (MULT, DIV): operands are converted to magnitudes at accept, and the sign flags are stored.
- RUN, multiply: radix-2 shift-add, one bit per cycle, producing a 2(msb+1)-bit product.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle.
- FIX:
  - Product: negated if operand signs differ. HI=upper half, LO=lower half.
  - Quotient: negated if signs differ, written to LO.
  - Remainder: takes the dividend's sign, written to HI.
  - Then go to IDLE and pulse out_done.
- 0x80000000 / 0xFFFFFFFF (signed DIV): LO=0x80000000, HI=0. No trap.
- Divide by zero, detected at accept: skip RUN and go straight to FIX. Result LO=0xFFFFFFFF, HI=in_rs_data, for both signed and unsigned.
- in_valid while not IDLE is ignored and has no side effect. The stall is the hazard unit's responsibility.
- flush (with db_ena) in RUN/FIX: go to IDLE, HI/LO unchanged, no done.
- flush in IDLE together with in_valid: flush wins, and nothing is accepted, including MTHI/MTLO.

## Timing
- Reset values: out_hi=0, out_lo=0, out_busy=0, out_done=0, state IDLE, counter 0. Reset is asynchronous and takes effect mid-operation, discarding partial results.
- Edge E0 accepts a mul/div. The RUN iterations occur at E1..E32, and FIX occurs at E33.
- HI/LO are visible after E33, out_done is high for the cycle after E33, and out_busy falls after E33.
- out_busy is registered: high from after E0 until after E33, i.e. 33 cycles.
- Divide by zero: FIX at E1, done and result after E1, out_busy high for 1 cycle.
- MTHI/MTLO: visible the cycle after the accepting edge. out_busy stays 0.
- db_ena low stretches the latency by exactly the number of disabled cycles, and the result is unchanged.
- A new operation can be accepted at the edge after done is asserted.

## Structure
- Shared package muldiv_pkg holds:
  - in_op encodings
  - FSM state encoding
  - iteration count constant (msb+1)
- Sub-module muldiv_step: combinational single iteration. It takes the accumulator/remainder, operand and mode, and returns the next accumulator and next bit. It is instanced once in ex_muldiv.
- ex_muldiv holds the FSM, counter, operand/sign latches and HI/LO.

## Test plan
- Reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 edges HI=0xFFFFFFFE, LO=0x00000001; done pulses 1 cycle; busy high exactly 33 cycles.
- MULT -7 x 3, then DIV -7/2 -> HI:LO=0xFFFFFFFF:0xFFFFFFEB; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> busy 1 cycle; LO=0xFFFFFFFF, HI=100. Signed DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0x5678 back-to-back -> HI=0x1234, LO=0x5678, busy never high; MTLO presented during a running DIVU is dropped.
- Start MULTU 5x6, flush at iteration 10 -> busy falls next cycle, no done, HI/LO keep prior values; async reset mid-DIV -> all outputs 0 immediately.
- MULTU 5x6 with db_ena low for 7 random cycles -> done after 41 edges, LO=30, HI=0.
